// File: rtl/fp16_pkg.sv
// Shared widths, in_sum bit positions and the normalize-stage payload
// for the FP16 adder back end.
package fp16_pkg;

  localparam int EXP_W    = 5;
  localparam int FRAC_W   = 10;
  localparam int EXP_BIAS = 15;
  localparam int EXP_MAX  = 31;

  localparam int SUM_OVF      = 14;
  localparam int SUM_HID      = 13;
  localparam int SUM_FRAC_LSB = 3;
  localparam int SUM_G        = 2;
  localparam int SUM_R        = 1;
  localparam int SUM_S        = 0;

  // Mantissa kept in hidden..sticky layout; exp carries one spare bit for the +1 case.
  typedef struct packed {
    logic               special;
    logic [15:0]        special_val;
    logic               zero;
    logic               sign;
    logic [EXP_W:0]     exp;
    logic [SUM_HID:0]   mant;
    logic               sticky;
  } s1_payload_t;

endpackage

// File: rtl/fp16_normalize_round_lzc.sv
// Leading-zero count of the 14-bit hidden..sticky field; count=14 when all zero.
module leading_zero_counter_16bits
  import fp16_pkg::*;
(
  input  logic [SUM_HID:0] data,
  output logic [3:0]       count,
  output logic             all_zero
);

  always_comb begin
    count    = 4'd14;
    all_zero = 1'b1;
    for (int i = 0; i <= SUM_HID; i++) begin
      if (data[i]) begin
        count    = 4'(SUM_HID - i);
        all_zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp16_normalize_round.sv
// Two-stage normalize + round-to-nearest-even for FP16 adder results;
// latency 2, one result per cycle, stalled stages hold their contents.
module fp16_normalize_round
  import fp16_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_sum,
  input  logic [EXP_W-1:0] in_exp,
  input  logic             in_sign,
  input  logic             in_sticky,
  input  logic             in_eff_sub,
  input  logic             in_special,
  input  logic [15:0]      in_special_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_result,
  output logic             out_overflow,
  output logic             out_underflow,
  output logic             out_inexact
);

  logic        s1_valid;
  s1_payload_t s1_q;
  s1_payload_t s1_d;
  logic        s1_advance;
  logic        s2_load;
  logic [3:0]  lz;
  logic        lz_zero;
  logic        sum_zero;

  leading_zero_counter_16bits u_lzc (
    .data     (in_sum[SUM_HID:0]),
    .count    (lz),
    .all_zero (lz_zero)
  );

  assign s2_load    = ~out_valid | out_ready;
  assign s1_advance = s1_valid & s2_load;
  assign in_ready   = ~s1_valid | s1_advance;
  assign sum_zero   = lz_zero & ~in_sum[SUM_OVF] & ~in_sum[15];

  always_comb begin
    s1_d             = '0;
    s1_d.special     = in_special;
    s1_d.special_val = in_special_val;
    s1_d.zero        = sum_zero;
    s1_d.sign        = in_sign & ~(sum_zero & in_eff_sub);
    s1_d.exp         = {1'b0, in_exp};
    s1_d.mant        = in_sum[SUM_HID:0];
    s1_d.sticky      = in_sticky;
    if (in_sum[SUM_OVF]) begin
      s1_d.mant   = in_sum[SUM_OVF:1];
      s1_d.exp    = {1'b0, in_exp} + 6'd1;
      s1_d.sticky = in_sticky | in_sum[0];
    end else if (!in_sum[SUM_HID] && !lz_zero) begin
      // Stop the left shift at exponent 1 and encode the result as subnormal.
      if ({2'b0, lz} < {1'b0, in_exp}) begin
        s1_d.mant = in_sum[SUM_HID:0] << lz;
        s1_d.exp  = {1'b0, in_exp} - {2'b0, lz};
      end else begin
        s1_d.mant = in_sum[SUM_HID:0] << (in_exp - 5'd1);
        s1_d.exp  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  logic [FRAC_W+1:0] mant_r;
  logic              grd;
  logic              rs;
  logic              inc;
  logic [EXP_W:0]    exp_f;
  logic [FRAC_W-1:0] frac_f;
  logic [15:0]       res_d;
  logic              ovf_d;
  logic              unf_d;
  logic              inx_d;

  always_comb begin
    grd    = s1_q.mant[SUM_G];
    rs     = s1_q.mant[SUM_R] | s1_q.mant[SUM_S] | s1_q.sticky;
    inc    = grd & (rs | s1_q.mant[SUM_FRAC_LSB]);
    mant_r = {1'b0, s1_q.mant[SUM_HID:SUM_FRAC_LSB]} + {{(FRAC_W+1){1'b0}}, inc};
    // A subnormal that rounds up into the hidden bit becomes the smallest normal.
    if (s1_q.exp == '0) exp_f = {{EXP_W{1'b0}}, mant_r[FRAC_W]};
    else                exp_f = s1_q.exp + {{EXP_W{1'b0}}, mant_r[FRAC_W+1]};
    frac_f = mant_r[FRAC_W+1] ? mant_r[FRAC_W:1] : mant_r[FRAC_W-1:0];
    res_d  = {s1_q.sign, exp_f[EXP_W-1:0], frac_f};
    ovf_d  = 1'b0;
    inx_d  = grd | rs;
    unf_d  = (exp_f == '0) & inx_d;
    if (s1_q.special) begin
      res_d = s1_q.special_val;
      inx_d = 1'b0;
      unf_d = 1'b0;
    end else if (s1_q.zero) begin
      res_d = {s1_q.sign, 15'h0};
      inx_d = 1'b0;
      unf_d = 1'b0;
    end else if (exp_f > 6'(2 * EXP_BIAS)) begin
      res_d = {s1_q.sign, 5'(EXP_MAX), {FRAC_W{1'b0}}};
      ovf_d = 1'b1;
      inx_d = 1'b1;
      unf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_result    <= 16'h0000;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result    <= res_d;
        out_overflow  <= ovf_d;
        out_underflow <= unf_d;
        out_inexact   <= inx_d;
      end
    end
  end

endmodule

// File: tb/tb_fp16_normalize_round.sv
// Scoreboard bench: directed corner cases, backpressure, mid-flight reset and
// randomized traffic checked against an arithmetic rounding model.
module tb_fp16_normalize_round;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_sum;
  logic [4:0]  in_exp;
  logic        in_sign;
  logic        in_sticky;
  logic        in_eff_sub;
  logic        in_special;
  logic [15:0] in_special_val;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;

  fp16_normalize_round dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sum         (in_sum),
    .in_exp         (in_exp),
    .in_sign        (in_sign),
    .in_sticky      (in_sticky),
    .in_eff_sub     (in_eff_sub),
    .in_special     (in_special),
    .in_special_val (in_special_val),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_overflow   (out_overflow),
    .out_underflow  (out_underflow),
    .out_inexact    (out_inexact)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [18:0] exp_q[$];
  int          tag_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          n_out = 0;
  int          rdy_mode = 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  // Real value of in_sum is sum * 2^(exp-15-13); round that to FP16 directly.
  function automatic logic [18:0] ref_model(input logic [15:0] s, input int e, input logic sg,
                                            input logic st, input logic es, input logic sp,
                                            input logic [15:0] sv);
    int          v, p, be, h, sh, q, rem, half, fld;
    bit          inx;
    logic [18:0] r;
    v = int'(s);
    if (sp) r = {sv, 3'b000};
    else if (v == 0) r = {sg & ~es, 15'h0, 3'b000};
    else begin
      p = 0;
      for (int i = 0; i < 16; i++) if (v[i]) p = i;
      be = e + p - 13;
      if (be < 1) be = 1;
      h  = 13 + be - e;
      sh = h - 10;
      if (sh <= 0) begin
        q   = v << (-sh);
        inx = st;
      end else begin
        q    = v >> sh;
        rem  = v & ((1 << sh) - 1);
        half = 1 << (sh - 1);
        inx  = (rem != 0) || st;
        if (rem > half || (rem == half && (st || q[0]))) q++;
      end
      if (q >= 2048) begin
        q = q / 2;
        be++;
      end
      fld = (q >= 1024) ? be : 0;
      if (fld >= 31) r = {sg, 5'h1F, 10'h0, 3'b101};
      else r = {sg, 5'(fld), 10'(q), 1'b0, (fld == 0) && inx, inx};
    end
    return r;
  endfunction

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom % 4) != 0;
      endcase
    end
  end

  // Monitor: pops on every transfer, and checks output stability while stalled.
  initial begin
    logic        held;
    logic [18:0] held_v;
    logic [18:0] cur;
    held = 1'b0;
    forever begin
      @(negedge clk);
      cur = {out_result, out_overflow, out_underflow, out_inexact};
      if (held && out_valid) check("hold_stable", cur, held_v);
      held = 1'b0;
      if (rst_n && out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: got %h want none", cur);
        end else begin
          check($sformatf("out_tag%0d", tag_q[0]), cur, exp_q[0]);
          void'(exp_q.pop_front());
          void'(tag_q.pop_front());
        end
      end else if (out_valid) begin
        held   = 1'b1;
        held_v = cur;
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [15:0] s, input logic [4:0] e, input logic sg, input logic st,
                      input logic es, input logic sp, input logic [15:0] sv,
                      input logic [18:0] want, input int tag);
    int waited = 0;
    in_sum = s; in_exp = e; in_sign = sg; in_sticky = st;
    in_eff_sub = es; in_special = sp; in_special_val = sv;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL accept_timeout tag%0d: got in_ready=0 want 1", tag);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(want);
      tag_q.push_back(tag);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic send_m(input logic [15:0] s, input logic [4:0] e, input logic sg, input logic st,
                        input logic es, input logic sp, input logic [15:0] sv, input int tag);
    send(s, e, sg, st, es, sp, sv, ref_model(s, int'(e), sg, st, es, sp, sv), tag);
  endtask

  task automatic drain();
    int k = 0;
    rdy_mode = 1;
    while (exp_q.size() != 0 && k < 500) begin
      @(posedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
      exp_q.delete();
      tag_q.delete();
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] s;
    logic [4:0]  e;
    int          mode;
    int          base;
    in_valid = 0; in_sum = 0; in_exp = 5'd1; in_sign = 0; in_sticky = 0;
    in_eff_sub = 0; in_special = 0; in_special_val = 0;
    rst_n = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_flags", {out_overflow, out_underflow, out_inexact}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1);
    @(posedge clk);
    #1;

    send(16'h4000, 5'd15, 0, 0, 0, 0, 16'h0, {16'h4000, 3'b000}, 1);
    @(negedge clk);
    check("lat_cycle1_valid", out_valid, 0);
    @(negedge clk);
    check("lat_cycle2_valid", out_valid, 1);
    @(posedge clk);
    #1;

    send(16'h2004, 5'd15, 0, 0, 0, 0, 16'h0, {16'h3C00, 3'b001}, 2);
    send(16'h200C, 5'd15, 0, 0, 0, 0, 16'h0, {16'h3C02, 3'b001}, 3);
    send(16'h0008, 5'd15, 0, 0, 1, 0, 16'h0, {16'h1400, 3'b000}, 4);
    send(16'h1000, 5'd1,  0, 0, 0, 0, 16'h0, {16'h0200, 3'b000}, 5);
    send(16'h7FF8, 5'd30, 0, 0, 0, 0, 16'h0, {16'h7C00, 3'b101}, 6);
    send(16'h0000, 5'd9,  1, 0, 0, 0, 16'h0, {16'h8000, 3'b000}, 7);
    send(16'h0000, 5'd9,  1, 1, 1, 0, 16'h0, {16'h0000, 3'b000}, 8);
    send(16'h2ABC, 5'd7,  1, 1, 0, 1, 16'h7E00, {16'h7E00, 3'b000}, 9);
    send(16'h1004, 5'd1,  0, 0, 0, 0, 16'h0, {16'h0200, 3'b011}, 10);
    send(16'h1FFC, 5'd1,  0, 0, 0, 0, 16'h0, {16'h0400, 3'b001}, 11);
    send(16'h2004, 5'd15, 0, 1, 0, 0, 16'h0, {16'h3C01, 3'b001}, 12);

    // Backpressure: third input must wait while both stages are full.
    drain();
    rdy_mode = 0;
    @(posedge clk);
    #2;
    send_m(16'h2123, 5'd10, 0, 0, 0, 0, 16'h0, 20);
    send_m(16'h4567, 5'd20, 1, 1, 0, 0, 16'h0, 21);
    in_sum = 16'h0ABC; in_exp = 5'd12; in_sign = 0; in_sticky = 0;
    in_eff_sub = 1; in_special = 0; in_valid = 1'b1;
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("bp_in_ready_still_low", in_ready, 0);
    rdy_mode = 1;
    @(posedge clk);
    #1;
    send_m(16'h0ABC, 5'd12, 0, 0, 1, 0, 16'h0, 22);

    // Reset with two results in flight: both must vanish.
    drain();
    rdy_mode = 0;
    @(posedge clk);
    #2;
    send_m(16'h2345, 5'd11, 0, 0, 0, 0, 16'h0, 30);
    send_m(16'h3001, 5'd18, 1, 0, 0, 0, 16'h0, 31);
    @(posedge clk);
    #2;
    check("pre_rst_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_inflight_out_valid", out_valid, 0);
    check("rst_inflight_out_result", out_result, 0);
    exp_q.delete();
    tag_q.delete();
    base = n_out;
    rdy_mode = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_rst_release", in_ready, 1);
    repeat (10) @(negedge clk);
    check("no_output_after_rst", n_out - base, 0);
    @(posedge clk);
    #1;

    rdy_mode = 2;
    for (int t = 0; t < 300; t++) begin
      mode = $urandom_range(0, 9);
      e    = 5'($urandom_range(1, 30));
      case (mode)
        0:       s = 16'h0000;
        1:       s = 16'($urandom & 32'h3FFF);
        2, 3, 4: s = 16'h4000 | 16'($urandom & 32'h3FFF);
        5, 6, 7: s = 16'h2000 | 16'($urandom & 32'h1FFF);
        default: begin
          s = 16'($urandom & 32'h3FFF) >> $urandom_range(0, 13);
          e = 5'($urandom_range(1, 6));
        end
      endcase
      if ($urandom % 3 == 0) begin
        @(posedge clk);
        #1;
      end
      send_m(s, e, 1'($urandom), 1'($urandom), 1'($urandom), mode == 1,
             16'($urandom), 100 + t);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
